msg_word_fetch: RTL and testbench

MSG_WORD_FETCH -- requirements
Module: msg_word_fetch

---
 rtl/msg_word_fetch_pkg.sv | 31 +++
 rtl/msg_word_fetch.sv | 162 ++++++++++++++++
 tb/tb_msg_word_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_word_fetch_pkg.sv
// Shared types and constants for the message word fetcher.
package msg_word_fetch_pkg;

  localparam int MSG_MAX_BYTES = 32;
  localparam int BW_SRAM_ADDR  = 5;
  localparam int BW_SRAM_DATA  = 8;
  localparam int WORD_BYTES    = 4;

  // Byte pointer must represent MSG_MAX_BYTES itself, hence one bit wider than the address.
  localparam int BW_PTR   = 6;
  localparam int BW_WORD  = WORD_BYTES * BW_SRAM_DATA;
  localparam int BW_BCNT  = 3;
  localparam int BW_LANE  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Clamp a requested length to the largest message the SRAM can hold.
  function automatic logic [BW_PTR-1:0] sat_len(input logic [BW_PTR-1:0] len);
    if (len > BW_PTR'(MSG_MAX_BYTES)) begin
      return BW_PTR'(MSG_MAX_BYTES);
    end
    return len;
  endfunction

endpackage

// File: rtl/msg_word_fetch.sv
// Reads a message byte-by-byte from a 32x8 SRAM and presents it as
// big-endian 32-bit words on a valid/ready interface.
module msg_word_fetch
  import msg_word_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BW_PTR-1:0]       msg_len,
  output logic                    sram_csb,
  output logic                    sram_wsb,
  output logic [BW_SRAM_ADDR-1:0] sram_raddr,
  input  logic [BW_SRAM_DATA-1:0] sram_rdata,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [BW_WORD-1:0]      word_data,
  output logic                    word_last,
  output logic [BW_BCNT-1:0]      word_bytes,
  output logic                    busy,
  output logic                    done
);

  state_t               state_reg;
  state_t               state_next;
  logic [BW_PTR-1:0]    ptr_reg;
  logic [BW_PTR-1:0]    len_reg;
  logic [BW_PTR-1:0]    ptr_inc;
  logic [BW_WORD-1:0]   word_reg;
  logic [BW_BCNT-1:0]   cnt_reg;
  logic                 pend_reg;
  logic [BW_LANE-1:0]   lane_reg;
  logic                 done_reg;

  logic                 load_msg;
  logic                 issue_rd;
  logic                 clear_word;
  logic                 ptr_at_end;
  logic [WORD_BYTES-1:0] lane_we;

  assign ptr_inc    = ptr_reg + BW_PTR'(1);
  assign ptr_at_end = (ptr_reg == len_reg);

  // One write enable per byte lane; lane 0 is the lowest address, stored in the top byte.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane_we
    assign lane_we[gi] = pend_reg && (lane_reg == BW_LANE'(gi));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and the control strobes that steer the datapath.
  always_comb begin
    state_next = state_reg;
    load_msg   = 1'b0;
    issue_rd   = 1'b0;
    clear_word = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (msg_len != '0) begin
            load_msg   = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_FIN;
          end
        end
      end
      ST_FETCH: begin
        issue_rd = 1'b1;
        // Stop after the fourth byte of this word or once the message runs out.
        if ((cnt_reg == BW_BCNT'(WORD_BYTES - 1)) || (ptr_inc == len_reg)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (word_ready) begin
          if (ptr_at_end) begin
            state_next = ST_FIN;
          end else begin
            clear_word = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pointer, length, per-word byte count and the one-deep read-pending tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= '0;
      len_reg  <= '0;
      cnt_reg  <= '0;
      pend_reg <= 1'b0;
      lane_reg <= '0;
    end else begin
      pend_reg <= issue_rd;
      if (load_msg) begin
        len_reg <= sat_len(msg_len);
        ptr_reg <= '0;
        cnt_reg <= '0;
      end else if (issue_rd) begin
        ptr_reg  <= ptr_inc;
        cnt_reg  <= cnt_reg + BW_BCNT'(1);
        lane_reg <= cnt_reg[BW_LANE-1:0];
      end else if (clear_word) begin
        cnt_reg <= '0;
      end
    end
  end

  // Word assembly: read data arrives the cycle after issue, so capture one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
    end else if (load_msg || clear_word) begin
      word_reg <= '0;
    end else begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane_we[i]) begin
          word_reg[BW_WORD-1-BW_SRAM_DATA*i -: BW_SRAM_DATA] <= sram_rdata;
        end
      end
    end
  end

  // Completion pulse follows the FIN state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_FIN);
    end
  end

  // Outputs decode from registered state, so reset reaches them without a clock edge.
  assign sram_wsb   = 1'b1;
  assign sram_csb   = (state_reg != ST_FETCH);
  assign sram_raddr = (state_reg == ST_FETCH) ? ptr_reg[BW_SRAM_ADDR-1:0] : '0;
  assign word_valid = (state_reg == ST_OUT);
  assign word_data  = word_reg;
  assign word_last  = (state_reg == ST_OUT) && ptr_at_end;
  assign word_bytes = (state_reg == ST_OUT) ? cnt_reg : '0;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;

endmodule

// File: tb/tb_msg_word_fetch.sv
// Scoreboard bench for msg_word_fetch with a behavioural 32x8 SRAM.
module tb_msg_word_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  msg_len;
  logic        sram_csb;
  logic        sram_wsb;
  logic [4:0]  sram_raddr;
  logic [7:0]  sram_rdata;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic [2:0]  word_bytes;
  logic        busy;
  logic        done;

  msg_word_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .msg_len    (msg_len),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_bytes (word_bytes),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          bytes;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem [32];
  logic [4:0]  rd_addr;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          cur_len = 0;
  int          exp_addr = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          rdy_mode = 1;
  bit          mon_en = 1'b0;
  bit          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // SRAM model: read data appears 1 ns after the issuing edge.
  always @(posedge clk) begin
    if (!sram_csb) begin
      rd_addr = sram_raddr;
      #1 sram_rdata = mem[rd_addr];
    end
  end

  // word_ready driver: 0 = hold low, 1 = hold high, 2 = random.
  initial begin
    word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       word_ready = 1'b0;
        1:       word_ready = 1'b1;
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares presented words against the queue head, checks addresses and timing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!sram_csb) begin
        chk("raddr", 32'(sram_raddr), 32'(exp_addr[4:0]));
        chk("addr_in_range", 32'(exp_addr < cur_len), 32'd1);
        exp_addr++;
      end
      if (word_valid) begin
        chk("csb_in_out", 32'(sram_csb), 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(word_data), 32'hFFFF_FFFF);
        end else begin
          if (!prev_valid) begin
            chk("word_latency", 32'(cyc - ref_cyc), 32'(q[0].bytes + 2));
          end
          chk("word_data", word_data, q[0].data);
          chk("word_last", 32'(word_last), 32'(q[0].last));
          chk("word_bytes", 32'(word_bytes), 32'(q[0].bytes));
          if (word_ready) begin
            $display("word %08h last=%0d bytes=%0d at cycle %0d", word_data, word_last, word_bytes, cyc);
            void'(q.pop_front());
            ref_cyc = cyc;
          end
        end
      end
      prev_valid = word_valid;
      if (done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: split the (saturated) message into 4-byte big-endian words.
  task automatic start_msg(input logic [5:0] len);
    int n;
    n = (len > 6'd32) ? 32 : int'(len);
    for (int off = 0; off < n; off += 4) begin
      exp_t e;
      e.bytes = ((n - off) >= 4) ? 4 : (n - off);
      e.data  = '0;
      for (int j = 0; j < e.bytes; j++) e.data[31 - 8*j -: 8] = mem[off + j];
      e.last  = (off + e.bytes == n);
      q.push_back(e);
    end
    cur_len  = n;
    exp_addr = 0;
    ref_cyc  = cyc;
    exp_done++;
    $display("start len=%0d (eff %0d) words=%0d at cycle %0d", len, n, q.size(), cyc);
    start   = 1'b1;
    msg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_valid(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (word_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csb"},   32'(sram_csb), 32'd1);
    chk({tag, "_wsb"},   32'(sram_wsb), 32'd1);
    chk({tag, "_raddr"}, 32'(sram_raddr), 32'd0);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_last"},  32'(word_last), 32'd0);
    chk({tag, "_bytes"}, 32'(word_bytes), 32'd0);
    chk({tag, "_data"},  word_data, 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    rst_n   = 1'b0;
    start   = 1'b0;
    msg_len = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Full 32-byte message, ready held high.
    rdy_mode = 1;
    d0 = done_cnt;
    start_msg(6'd32);
    wait_done(200);
    tick();
    chk("full_done_once", 32'(done_cnt - d0), 32'd1);
    chk("full_queue_empty", 32'(q.size()), 32'd0);

    // Partial final word.
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'hA0 + i);
    start_msg(6'd6);
    wait_done(100);

    // Zero length: busy only in T+1, done in T+2.
    start_msg(6'd0);
    chk("zl_busy_t1", 32'(busy), 32'd1);
    chk("zl_done_t1", 32'(done), 32'd0);
    tick();
    chk("zl_busy_t2", 32'(busy), 32'd0);
    chk("zl_done_t2", 32'(done), 32'd1);
    tick();
    chk("zl_done_t3", 32'(done), 32'd0);

    // Backpressure on the first word for 10 cycles.
    rdy_mode = 0;
    start_msg(6'd8);
    wait_valid(20);
    repeat (10) tick();
    rdy_mode = 1;
    wait_done(100);

    // Start during OUT must be ignored.
    rdy_mode = 0;
    start_msg(6'd8);
    wait_valid(20);
    tick();
    start   = 1'b1;
    msg_len = 6'd3;
    tick();
    start   = 1'b0;
    tick();
    rdy_mode = 1;
    wait_done(100);

    // Reset mid-FETCH, then restart immediately.
    start_msg(6'd20);
    tick();
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    q.delete();
    exp_done--;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    prev_valid = 1'b0;
    mon_en     = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    start_msg(6'd4);
    wait_done(100);

    // Randomised messages, including oversize lengths and random backpressure.
    for (int m = 0; m < 40; m++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      rdy_mode = $urandom_range(1, 2);
      start_msg(6'($urandom_range(0, 63)));
      wait_done(600);
    end

    rdy_mode = 1;
    repeat (4) tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    chk("final_done_count", 32'(done_cnt), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
